seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Recovers digit values from a time-multiplexed, active-low seven-segment display bus: the same segment encoding the display drivers produce. It watches the anode-select and segment lines and waits for each pattern to settle. It then decodes the settled pattern back to a 4-bit value and stores it per digit position. The block sits on the board-test and loopback path, where it checks what the pipeline actually drove onto the display.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required before a capture (2..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines, active-low, bit 0 = segment a … bit 6 = segment g.
- dig_sel  in  DIGITS  anode select, active-low one-hot; bit i low selects position i.
- digits_out  out  4*DIGITS  decoded value per position; position i at [4i+3:4i].
- digit_valid  out  DIGITS  bit i = 1 when position i last decoded as 0–9.
- err_pulse  out  1  one-cycle pulse on capture of an unrecognised pattern.
- err_count  out  8  count of err_pulse events, saturating at 255.
- frame_done  out  1  one-cycle pulse when every position has been captured since the last frame_done.

## Operation
- Input stage: {dig_sel, seg_in} registered once into sample register S. A stability counter C compares S with the previous S.
- Counter rules:
  - If S changed, C = 1.
  - Otherwise, C increments, saturating at STABLE_CYCLES.
  - If dig_sel in S is all-ones, or has more than one bit low, C is held at 0 and no capture occurs.
- States:
  - IDLE: after reset or illegal select. Goes to TRACK on a legal select.
  - TRACK: C counting. Goes to CAPTURE when C reaches STABLE_CYCLES.
  - CAPTURE: one cycle; outputs updated. Goes to HOLD.
  - HOLD: no further captures until S changes. Then goes to TRACK with C = 1, or to IDLE if the new select is illegal.
- Decode table (seg_in → value):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
- Capture into the selected position i:
  - Table hit: digits_out[i] = value, digit_valid[i] = 1.
  - Blank (1111111): digits_out[i] = 4'hF, digit_valid[i] = 0; no error.
  - Any other pattern: digits_out[i] retained, digit_valid[i] = 0, err_pulse = 1, err_count increments (saturating).
- Frame tracking:
  - A seen-mask bit i is set on every capture to position i, including blank and error captures.
  - A capture that completes the mask pulses frame_done on the same cycle the outputs update, and clears the mask that cycle.
  - Re-capturing an already-seen position rewrites its value and leaves the mask unchanged.

## Timing
- Reset values: digits_out all 4'hF; digit_valid 0; err_pulse 0; err_count 0; frame_done 0; mask 0; C 0; state IDLE; S all-ones.
- Latency: an input pair held constant from edge n becomes S at edge n+1. C reaches STABLE_CYCLES at edge n+STABLE_CYCLES. Outputs update at edge n+STABLE_CYCLES+1.
- A pair held for fewer than STABLE_CYCLES samples never captures.
- One capture per stable interval, however long the pair is held.
- err_pulse and frame_done are registered, one clock wide, and coincident with the output update.
- rst asserted mid-TRACK or mid-CAPTURE abandons the capture. All outputs take their reset values at that edge.
- rst has priority over every other event.

## Test plan
- Reset with rst high 2 cycles, no stimulus → digits_out = 16'hFFFF, digit_valid = 4'b0000, err_count = 0, frame_done never pulses.
- dig_sel = 4'b1110 and seg_in = 7'b0100100 held from edge 0 → digits_out[3:0] = 4'h2 and digit_valid = 4'b0001 at edge 5 and not before; held 20 cycles → exactly one update.
- Glitch: pair held 3 cycles, then changed to dig_sel = 4'b1111 → no output change, C returns to 0.
- Scan positions 0..3 with digits 1, 2, 3, 4, each held 6 cycles → digits_out = 16'h4321, digit_valid = 4'b1111, one frame_done pulse on the 4th capture. A second identical scan gives a second single pulse.
- Error and blank cases:
  - seg_in = 7'b0101010 on position 1 after it held 2 → err_pulse one cycle, err_count = 1, digits_out[7:4] stays 4'h2, digit_valid[1] = 0.
  - Then seg_in = 7'b1111111 on position 1 → digits_out[7:4] = 4'hF, no err_pulse.
  - 300 consecutive error captures → err_count = 255.
- Illegal select:
  - dig_sel = 4'b1100, held 10 cycles → no capture.
  - Mid-TRACK on a legal pair, rst pulsed at C = 3 → all outputs at reset values, no capture follows until a fresh STABLE_CYCLES interval.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Recovers digit values from an active-low, time-multiplexed seven-segment bus.
// Each {dig_sel, seg_in} pair is captured once, after it has been stable long enough.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  err_pulse,
  output logic [7:0]            err_count,
  output logic                  frame_done
);

  localparam int SW = DIGITS + 7;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TRACK   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;
  localparam logic [7:0] C_MAX      = 8'(STABLE_CYCLES);

  logic [SW-1:0]       s_q, s_d;
  logic [7:0]          c_q, c_d;
  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                err_pulse_q, err_pulse_d;
  logic [7:0]          err_count_q, err_count_d;
  logic                frame_done_q, frame_done_d;

  logic                changed;
  logic                legal_d;
  logic                capture;
  logic [DIGITS-1:0]   cap_sel;
  logic [DIGITS-1:0]   wr;
  logic [4:0]          dec;
  logic                is_blank;
  logic                is_err;
  logic [DIGITS-1:0]   mask_or;

  // Legal select: exactly one anode line driven low.
  function automatic logic sel_legal(input logic [DIGITS-1:0] sel);
    logic [DIGITS-1:0] a;
    a = ~sel;
    return (a != '0) && ((a & (a - 1'b1)) == '0);
  endfunction

  // Returns {hit, value}; value is don't-care when hit is 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      default:    return {1'b0, 4'hF};
    endcase
  endfunction

  // The stability count is computed against the incoming sample, so C = 1
  // on the same edge that loads a new pair into S.
  always_comb begin
    s_d     = {dig_sel, seg_in};
    changed = (s_d != s_q);
    legal_d = sel_legal(s_d[SW-1:7]);
    c_d     = c_q;
    if (!legal_d)          c_d = 8'd0;
    else if (changed)      c_d = 8'd1;
    else if (c_q != C_MAX) c_d = c_q + 8'd1;

    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = legal_d ? ST_TRACK : ST_IDLE;
      ST_TRACK:   state_d = !legal_d ? ST_IDLE : ((c_d == C_MAX) ? ST_CAPTURE : ST_TRACK);
      ST_CAPTURE: state_d = !legal_d ? ST_IDLE : (changed ? ST_TRACK : ST_HOLD);
      default:    state_d = !legal_d ? ST_IDLE : (changed ? ST_TRACK : ST_HOLD);
    endcase
  end

  assign capture  = (state_q == ST_CAPTURE);
  assign cap_sel  = ~s_q[SW-1:7];
  assign dec      = decode_seg(s_q[6:0]);
  assign is_blank = (s_q[6:0] == 7'b1111111);
  assign is_err   = capture && !dec[4] && !is_blank;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign wr[gi] = capture & cap_sel[gi];
    assign digits_d[4*gi +: 4] = (wr[gi] && dec[4])   ? dec[3:0] :
                                 (wr[gi] && is_blank) ? 4'hF     :
                                                        digits_q[4*gi +: 4];
    assign valid_d[gi] = wr[gi] ? dec[4] : valid_q[gi];
  end

  assign mask_or      = mask_q | cap_sel;
  assign frame_done_d = capture && (&mask_or);
  assign mask_d       = !capture ? mask_q : ((&mask_or) ? '0 : mask_or);
  assign err_pulse_d  = is_err;
  assign err_count_d  = (is_err && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q          <= '1;
      c_q          <= 8'd0;
      state_q      <= ST_IDLE;
      digits_q     <= '1;
      valid_q      <= '0;
      mask_q       <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      s_q          <= s_d;
      c_q          <= c_d;
      state_q      <= state_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      mask_q       <= mask_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;
  assign frame_done  = frame_done_q;

endmodule
